// File: rtl/parking_pkg.sv
// Shared types for the parking-lot entry/exit sensor decoder: FSM states and sensor codes.
package parking_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEnt1,
    StEnt2,
    StEnt3,
    StEx1,
    StEx2,
    StEx3,
    StResync
  } parking_state_t;

  // Sensor pair s = {a, b}; 1 = beam blocked.
  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_A     = 2'b10;
  localparam logic [1:0] S_BOTH  = 2'b11;
  localparam logic [1:0] S_B     = 2'b01;

endpackage

// File: rtl/parking_sensor_fsm_if.sv
// Sensor inputs and counter-pulse outputs of the parking sensor decoder.
interface parking_sensor_fsm_if;

  logic a;
  logic b;
  logic inc;
  logic dec;
  logic fault;

  modport master (
    output a,
    output b,
    input  inc,
    input  dec,
    input  fault
  );

  modport slave (
    input  a,
    input  b,
    output inc,
    output dec,
    output fault
  );

endinterface

// File: rtl/parking_sensor_fsm_core.sv
// Sensor sequence decoder: emits inc/dec pulses on completed entries/exits and flags stalls.
module parking_sensor_fsm_core
  import parking_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_sensor_fsm_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STALL_LIMIT);

  logic [1:0]     s;
  logic [1:0]     s_prev_q;
  parking_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;
  logic           fault_q, fault_d;

  assign s = {bus.a, bus.b};

  // Each state holds on its own code, steps back on its predecessor's code.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        case (s)
          S_CLEAR: state_d = StIdle;
          S_A:     state_d = StEnt1;
          S_B:     state_d = StEx1;
          default: state_d = StResync;
        endcase
      end
      StEnt1: begin
        case (s)
          S_A:     state_d = StEnt1;
          S_BOTH:  state_d = StEnt2;
          S_CLEAR: state_d = StIdle;
          default: state_d = StResync;
        endcase
      end
      StEnt2: begin
        case (s)
          S_BOTH:  state_d = StEnt2;
          S_B:     state_d = StEnt3;
          S_A:     state_d = StEnt1;
          default: state_d = StResync;
        endcase
      end
      StEnt3: begin
        case (s)
          S_B:     state_d = StEnt3;
          S_BOTH:  state_d = StEnt2;
          S_CLEAR: begin
            state_d = StIdle;
            inc_d   = 1'b1;
          end
          default: state_d = StResync;
        endcase
      end
      StEx1: begin
        case (s)
          S_B:     state_d = StEx1;
          S_BOTH:  state_d = StEx2;
          S_CLEAR: state_d = StIdle;
          default: state_d = StResync;
        endcase
      end
      StEx2: begin
        case (s)
          S_BOTH:  state_d = StEx2;
          S_A:     state_d = StEx3;
          S_B:     state_d = StEx1;
          default: state_d = StResync;
        endcase
      end
      StEx3: begin
        case (s)
          S_A:     state_d = StEx3;
          S_BOTH:  state_d = StEx2;
          S_CLEAR: begin
            state_d = StIdle;
            dec_d   = 1'b1;
          end
          default: state_d = StResync;
        endcase
      end
      StResync: begin
        if (s == S_CLEAR) state_d = StIdle;
      end
      default: state_d = StResync;
    endcase
  end

  // Stall counter saturates; any sensor change or IDLE clears it.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == StIdle) || (state_d == StIdle) || (s != s_prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    fault_d = (cnt_d == CntMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StResync;
      s_prev_q <= S_CLEAR;
      cnt_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_prev_q <= s;
      cnt_q    <= cnt_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.inc   = inc_q;
  assign bus.dec   = dec_q;
  assign bus.fault = fault_q;

endmodule

// File: rtl/sync2.sv
// One-bit two-flop synchronizer with asynchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/parking_sensor_fsm.sv
// Parking sensor decoder top. Define PARKING_SENSOR_SYNC_EN to add 2-flop input synchronizers.
module parking_sensor_fsm #(
  parameter int unsigned STALL_LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec,
  output logic fault
);

  parking_sensor_fsm_if bus ();

`ifdef PARKING_SENSOR_SYNC_EN
  logic a_sync;
  logic b_sync;

  sync2 u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (a_sync)
  );

  sync2 u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (b),
    .q     (b_sync)
  );

  assign bus.a = a_sync;
  assign bus.b = b_sync;
`else
  // Inputs must already be synchronous to clk in this build.
  assign bus.a = a;
  assign bus.b = b;
`endif

  parking_sensor_fsm_core #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign inc   = bus.inc;
  assign dec   = bus.dec;
  assign fault = bus.fault;

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Scoreboard bench for parking_sensor_fsm: expected pulses/fault edges queued with cycle stamps.
module tb_parking_sensor_fsm;

  localparam int unsigned StallLimit = 8;
`ifdef PARKING_SENSOR_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif
  localparam int KInc = 1;
  localparam int KDec = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_sensor_fsm_if bus ();

  parking_sensor_fsm #(
    .STALL_LIMIT (StallLimit)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (bus.a),
    .b     (bus.b),
    .inc   (bus.inc),
    .dec   (bus.dec),
    .fault (bus.fault)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int exp_kind[$];
  int exp_cyc[$];
  int exp_flvl[$];
  int exp_fcyc[$];

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pop_pulse(input int kind);
    int k;
    int c;
    if (exp_kind.size() == 0) begin
      check("unexpected_pulse", kind, 0);
    end else begin
      k = exp_kind.pop_front();
      c = exp_cyc.pop_front();
      check("pulse_kind", kind, k);
      check("pulse_cycle", cyc, c);
    end
  endtask

  // Monitor: sample 1 time unit after every rising edge.
  initial begin : monitor
    int inc_run;
    int dec_run;
    logic prev_fault;
    int lvl;
    int fc;
    inc_run = 0;
    dec_run = 0;
    prev_fault = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.inc && bus.dec) check("inc_dec_exclusive", 1, 0);
      if (bus.inc) begin
        if (inc_run == 0) pop_pulse(KInc);
        inc_run++;
      end else begin
        if (inc_run != 0) check("inc_width", inc_run, 1);
        inc_run = 0;
      end
      if (bus.dec) begin
        if (dec_run == 0) pop_pulse(KDec);
        dec_run++;
      end else begin
        if (dec_run != 0) check("dec_width", dec_run, 1);
        dec_run = 0;
      end
      if (bus.fault !== prev_fault) begin
        if (exp_flvl.size() == 0) begin
          check("unexpected_fault_edge", int'(bus.fault), int'(prev_fault));
        end else begin
          lvl = exp_flvl.pop_front();
          fc  = exp_fcyc.pop_front();
          check("fault_level", int'(bus.fault), lvl);
          check("fault_cycle", cyc, fc);
        end
        prev_fault = bus.fault;
      end
    end
  end

  // Call between a falling and the next rising edge; holds s for n rising edges.
  task automatic drive(input logic [1:0] s, input int n, input int kind);
    if (kind != 0) begin
      exp_kind.push_back(kind);
      exp_cyc.push_back(cyc + 1 + Lat - 1);
    end
    bus.a = s[1];
    bus.b = s[0];
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic full_entry();
    drive(2'b10, 3, 0);
    drive(2'b11, 3, 0);
    drive(2'b01, 3, 0);
    drive(2'b00, 3, KInc);
  endtask

  task automatic full_exit();
    drive(2'b01, 3, 0);
    drive(2'b11, 3, 0);
    drive(2'b10, 3, 0);
    drive(2'b00, 3, KDec);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inc"},   int'(bus.inc),   0);
    check({tag, "_dec"},   int'(bus.dec),   0);
    check({tag, "_fault"}, int'(bus.fault), 0);
  endtask

  initial begin : stimulus
    int n_edge;
    bus.a = 1'b0;
    bus.b = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 3, 0);

    // Entry, then two back-to-back exits.
    full_entry();
    full_exit();
    full_exit();

    // Aborted entry returns to IDLE; immediate exit must still count.
    drive(2'b10, 3, 0);
    drive(2'b11, 3, 0);
    drive(2'b10, 3, 0);
    drive(2'b00, 1, 0);
    full_exit();

    // Reset mid-entry in ENT2.
    drive(2'b10, 3, 0);
    drive(2'b11, 3, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01, 3, 0);
    drive(2'b00, 3, 0);
    full_entry();

    // Stall in ENT2: fault after StallLimit unchanged samples, clears on s=01.
    drive(2'b10, 3, 0);
    n_edge = cyc + 1;
    exp_flvl.push_back(1);
    exp_fcyc.push_back(n_edge + int'(StallLimit) + Lat - 1);
    exp_flvl.push_back(0);
    exp_fcyc.push_back(n_edge + 12 + Lat - 1);
    drive(2'b11, 12, 0);
    drive(2'b01, 3, 0);
    drive(2'b00, 3, KInc);

    // IDLE straight to both-blocked goes to RESYNC; clears back to IDLE.
    drive(2'b11, 3, 0);
    drive(2'b00, 3, 0);
    full_entry();

    drive(2'b00, 5, 0);
    check("pending_pulses", exp_kind.size(), 0);
    check("pending_fault_edges", exp_flvl.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parking_sensor_fsm.md
PARKING_SENSOR_FSM -- requirements
Module: parking_sensor_fsm

Interface
REQ-001 SHALL provide parameter STALL_LIMIT, default 1000: cycles with unchanged sensors in a non-IDLE state before fault is raised.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset; block is held in reset while reset==0.
REQ-004 SHALL provide port a  input  1  outer photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-005 SHALL provide port b  input  1  inner photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-006 SHALL provide port inc  output  1  registered one-cycle pulse per completed entry; drives the occupancy counter's inc.
REQ-007 SHALL provide port dec  output  1  registered one-cycle pulse per completed exit; drives the occupancy counter's dec.
REQ-008 SHALL provide port fault  output  1  registered level; high while a stall is detected.

Function
REQ-009 SHALL decode sensor pair s={a,b} (synchronized per REQ-020) with FSM states IDLE, ENT1, ENT2, ENT3, EX1, EX2, EX3, RESYNC.
REQ-010 SHALL take entry path IDLE -s=10-> ENT1 -s=11-> ENT2 -s=01-> ENT3 -s=00-> IDLE, pulsing inc for exactly one cycle on the ENT3->IDLE transition.
REQ-011 SHALL take exit path IDLE -s=01-> EX1 -s=11-> EX2 -s=10-> EX3 -s=00-> IDLE, pulsing dec for exactly one cycle on the EX3->IDLE transition.
REQ-012 SHALL hold state when s is unchanged, and step back one state when s equals the previous state's code (car reversing), with no pulse.
REQ-013 SHALL return ENT1 or EX1 to IDLE on s=00 with no pulse (car backed out).
REQ-014 SHALL enter RESYNC on any other transition (e.g. IDLE s=11, ENT1 s=01, ENT2 s=00), emitting no pulse.
REQ-015 SHALL leave RESYNC for IDLE only on a cycle with s=00.
REQ-016 SHALL never assert inc and dec in the same cycle; each SHALL be low in all cycles other than REQ-010/011 transitions.
REQ-017 SHALL count cycles with s unchanged while not in IDLE, saturating at STALL_LIMIT; fault=1 while count==STALL_LIMIT; counter and fault clear the cycle after any s change or entry to IDLE; FSM state is unaffected by fault.
REQ-018 SHALL size the stall counter as $clog2(STALL_LIMIT+1) bits, with no wrap.

Reset
REQ-019 SHALL, on reset==0, immediately force state=RESYNC, inc=0, dec=0, fault=0, stall counter=0, synchronizer flops=0; reset mid-car discards the partial sequence and no pulse results until sensors clear.

Configuration
REQ-020 SHALL, with macro PARKING_SENSOR_SYNC_EN defined, pass a and b through 2-flop synchronizers: a sensor change reaches inc/dec/fault 3 clock edges after it is sampled.
REQ-021 SHALL, without PARKING_SENSOR_SYNC_EN, feed a and b to the FSM directly: latency 1 edge; inputs are then required to be synchronous to clk.

Structure
REQ-022 SHALL place the FSM state enum typedef (parking_state_t) and the sensor codes (S_CLEAR=00, S_A=10, S_BOTH=11, S_B=01) in package parking_pkg.
REQ-023 SHALL implement synchronization as sub-module sync2 (one bit, async active-low reset), instantiated twice only when PARKING_SENSOR_SYNC_EN is defined.

Verification
REQ-024 Bench SHALL cover: s=00,10,11,01,00, each held 3 cycles -> exactly one inc pulse, dec never high.
REQ-025 Bench SHALL cover: s=00,01,11,10,00 -> exactly one dec pulse; two back-to-back exits -> two dec pulses.
REQ-026 Bench SHALL cover: s=10,11,10,00 (entry aborted) -> no inc/dec, state ends IDLE.
REQ-027 Bench SHALL cover: reset=0 while in ENT2 with s=11, release, then s=01,00 -> no pulse; next full entry -> one inc.
REQ-028 Bench SHALL cover: STALL_LIMIT=8, hold s=11 in ENT2 for 12 cycles -> fault rises after 8 unchanged cycles, clears the cycle after s=01; then s=00 -> one inc.
REQ-029 Bench SHALL cover: IDLE with s=11 direct -> RESYNC, no pulse; s=00 -> IDLE.
